// File: rtl/fetch_pkg.sv
// Shared fetch definitions: sequencer states, default widths and the halt word.
// Pure declarations, no latency or flow control of its own.
package fetch_pkg;

    localparam int DEF_PCW = 10;
    localparam int DEF_IW  = 9;
    localparam int DEF_OPW = 3;

    localparam logic [DEF_IW-1:0] DEF_HALT_INSTR = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch <-> ROM/decoder bundle; the slave side is the fetch sequencer.
// No storage; ROM data is expected one cycle after RomAddr is sampled.
interface inst_fetch_if #(
    parameter int PCW = fetch_pkg::DEF_PCW,
    parameter int IW  = fetch_pkg::DEF_IW,
    parameter int OPW = fetch_pkg::DEF_OPW
) ();

    logic            Start;
    logic [IW-1:0]   RomData;
    logic            Branch;
    logic            BrTaken;
    logic [PCW-1:0]  BrTarget;
    logic [PCW-1:0]  RomAddr;
    logic [IW-1:0]   Instr;
    logic [OPW-1:0]  ALUOp;
    logic            InstrValid;
    logic            Done;
    logic [15:0]     InstrCount;

    modport master (
        output Start, RomData, Branch, BrTaken, BrTarget,
        input  RomAddr, Instr, ALUOp, InstrValid, Done, InstrCount
    );

    modport slave (
        input  Start, RomData, Branch, BrTaken, BrTarget,
        output RomAddr, Instr, ALUOp, InstrValid, Done, InstrCount
    );

endinterface

// File: rtl/prog_ctr.sv
// Program counter register with load, wrapping increment and hold.
// One-cycle update; load wins over increment, neither means hold.
module prog_ctr #(
    parameter int             PCW     = 10,
    parameter logic [PCW-1:0] RST_VAL = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_load,
    input  logic           i_inc,
    input  logic [PCW-1:0] i_load_val,
    output logic [PCW-1:0] o_pc
);

    logic [PCW-1:0] r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RST_VAL;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + PCW'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch sequencer: PC, ROM addressing, squash of stale words, halt/run control.
// One instruction per cycle, one-cycle ROM latency; taken branch costs one bubble.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int             PCW        = DEF_PCW,
    parameter int             IW         = DEF_IW,
    parameter int             OPW        = DEF_OPW,
    parameter logic [PCW-1:0] START_ADDR = '0,
    parameter logic [IW-1:0]  HALT_INSTR = DEF_HALT_INSTR
) (
    input  logic         Clk,
    input  logic         Reset_n,
    inst_fetch_if.slave  bus
);

    fetch_state_e   r_state;
    fetch_state_e   w_state_nxt;
    logic           r_squash;
    logic           w_squash_nxt;
    logic [15:0]    r_cnt;
    logic [15:0]    w_cnt_nxt;

    logic           w_valid;
    logic           w_halt;
    logic           w_redirect;
    logic           w_pc_load;
    logic           w_pc_inc;
    logic [PCW-1:0] w_pc_val;
    logic [PCW-1:0] w_pc;

    // Squash marks RomData as belonging to an address we no longer want.
    assign w_valid    = (r_state == RUN) && !r_squash;
    assign w_halt     = w_valid && (bus.RomData == HALT_INSTR);
    assign w_redirect = w_valid && bus.Branch && bus.BrTaken && !w_halt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= IDLE;
            r_squash <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_squash <= w_squash_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_squash_nxt = r_squash;
        w_cnt_nxt    = r_cnt;
        w_pc_load    = 1'b0;
        w_pc_inc     = 1'b0;
        w_pc_val     = START_ADDR;
        case (r_state)
            IDLE, HALT: begin
                if (bus.Start) begin
                    w_state_nxt  = RUN;
                    w_squash_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                    w_pc_load    = 1'b1;
                end
            end
            RUN: begin
                if (w_valid) begin
                    w_cnt_nxt = sat_inc16(r_cnt);
                end
                if (w_halt) begin
                    w_state_nxt = HALT;
                end else if (w_redirect) begin
                    w_pc_load    = 1'b1;
                    w_pc_val     = bus.BrTarget;
                    w_squash_nxt = 1'b1;
                end else begin
                    w_pc_inc     = 1'b1;
                    w_squash_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    prog_ctr #(
        .PCW     (PCW),
        .RST_VAL (START_ADDR)
    ) u_prog_ctr (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .i_load     (w_pc_load),
        .i_inc      (w_pc_inc),
        .i_load_val (w_pc_val),
        .o_pc       (w_pc)
    );

    assign bus.RomAddr    = w_pc;
    assign bus.Instr      = bus.RomData;
    assign bus.ALUOp      = bus.RomData[IW-1 -: OPW];
    assign bus.InstrValid = w_valid;
    assign bus.Done       = (r_state == HALT);
    assign bus.InstrCount = r_cnt;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: per-cycle expectations queued with each program run.
module tb_inst_fetch;
    import fetch_pkg::*;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    inst_fetch_if #(.PCW(10), .IW(9), .OPW(3)) b0 ();
    inst_fetch_if #(.PCW(4),  .IW(9), .OPW(3)) b1 ();

    inst_fetch u_dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (b0)
    );

    inst_fetch #(.PCW(4), .START_ADDR(4'd14)) u_wrap (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (b1)
    );

    logic [8:0] rom0 [1024];
    logic [8:0] rom1 [16];
    logic       taken;

    always @(posedge Clk) b0.RomData <= rom0[b0.RomAddr];
    always @(posedge Clk) b1.RomData <= rom1[b1.RomAddr];

    // Decoder stand-in: opcode 3'b110 is a branch to the low 6 bits.
    assign b0.Branch   = (b0.Instr[8:6] == 3'b110);
    assign b0.BrTaken  = taken;
    assign b0.BrTarget = {4'b0000, b0.Instr[5:0]};
    assign b1.Branch   = 1'b0;
    assign b1.BrTaken  = 1'b0;
    assign b1.BrTarget = '0;

    typedef struct {
        logic        vld;
        logic [9:0]  addr;
        logic [8:0]  instr;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] m_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic vld, input logic [9:0] addr, input logic [8:0] instr, input logic done);
        exp_t e;
        e.vld   = vld;
        e.addr  = addr;
        e.instr = instr;
        e.done  = done;
        e.cnt   = m_cnt;
        exp_q.push_back(e);
        if (vld) m_cnt++;
    endtask

    task automatic set_start(input int d, input logic v);
        if (d == 0) b0.Start = v;
        else        b1.Start = v;
    endtask

    // Called at a negedge: Start is sampled by the next posedge, checks begin the negedge after.
    task automatic run_check(input int d, input int pulse_at);
        int          cyc;
        exp_t        e;
        logic        vld;
        logic        done;
        logic [9:0]  addr;
        logic [8:0]  ins;
        logic [2:0]  op;
        logic [15:0] cnt;
        cyc = 0;
        set_start(d, 1'b1);
        @(posedge Clk);
        @(negedge Clk);
        set_start(d, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (d == 0) begin
                vld = b0.InstrValid; done = b0.Done; addr = b0.RomAddr;
                ins = b0.Instr; op = b0.ALUOp; cnt = b0.InstrCount;
            end else begin
                vld = b1.InstrValid; done = b1.Done; addr = {6'b0, b1.RomAddr};
                ins = b1.Instr; op = b1.ALUOp; cnt = b1.InstrCount;
            end
            check_val($sformatf("d%0d c%0d valid", d, cyc), vld, e.vld);
            check_val($sformatf("d%0d c%0d addr", d, cyc), addr, e.addr);
            check_val($sformatf("d%0d c%0d done", d, cyc), done, e.done);
            check_val($sformatf("d%0d c%0d count", d, cyc), cnt, e.cnt);
            if (e.vld) begin
                check_val($sformatf("d%0d c%0d instr", d, cyc), ins, e.instr);
                check_val($sformatf("d%0d c%0d aluop", d, cyc), op, e.instr[8:6]);
            end
            set_start(d, cyc == pulse_at);
            cyc++;
            @(negedge Clk);
        end
        set_start(d, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b0.Start = 1'b0;
        b1.Start = 1'b0;
        taken    = 1'b0;
        for (int i = 0; i < 1024; i++) rom0[i] = 9'h000;
        for (int i = 0; i < 16; i++)   rom1[i] = 9'h000;

        repeat (2) @(negedge Clk);
        check_val("rst addr",  b0.RomAddr, 10'd0);
        check_val("rst valid", b0.InstrValid, 1'b0);
        check_val("rst done",  b0.Done, 1'b0);
        check_val("rst count", b0.InstrCount, 16'd0);
        check_val("rst wrap addr", b1.RomAddr, 4'd14);
        Reset_n = 1'b1;
        @(negedge Clk);
        check_val("idle addr", b0.RomAddr, 10'd0);

        // Straight-line program ending in halt
        rom0[0] = 9'h001; rom0[1] = 9'h002; rom0[2] = 9'h003; rom0[3] = 9'h1FF;
        m_cnt = 0;
        push(0, 0, 9'h000, 0);
        push(1, 1, 9'h001, 0);
        push(1, 2, 9'h002, 0);
        push(1, 3, 9'h003, 0);
        push(1, 4, 9'h1FF, 0);
        push(0, 4, 9'h000, 1);
        push(0, 4, 9'h000, 1);
        run_check(0, -1);

        // Taken branch at word 2 to address 20; restart from HALT
        rom0[2] = 9'h194; rom0[3] = 9'h003; rom0[20] = 9'h00A; rom0[21] = 9'h1FF;
        taken = 1'b1;
        m_cnt = 0;
        push(0, 0,  9'h000, 0);
        push(1, 1,  9'h001, 0);
        push(1, 2,  9'h002, 0);
        push(1, 3,  9'h194, 0);
        push(0, 20, 9'h000, 0);
        push(1, 21, 9'h00A, 0);
        push(1, 22, 9'h1FF, 0);
        push(0, 22, 9'h000, 1);
        run_check(0, -1);

        // Not-taken branch, plus a Start pulse mid-run that must be ignored
        rom0[4] = 9'h004; rom0[5] = 9'h1FF;
        taken = 1'b0;
        m_cnt = 0;
        push(0, 0, 9'h000, 0);
        push(1, 1, 9'h001, 0);
        push(1, 2, 9'h002, 0);
        push(1, 3, 9'h194, 0);
        push(1, 4, 9'h003, 0);
        push(1, 5, 9'h004, 0);
        push(1, 6, 9'h1FF, 0);
        push(0, 6, 9'h000, 1);
        run_check(0, 2);

        // Address wrap on the 4-bit instance starting at 14
        rom1[14] = 9'h021; rom1[15] = 9'h022; rom1[0] = 9'h023; rom1[1] = 9'h1FF;
        m_cnt = 0;
        push(0, 14, 9'h000, 0);
        push(1, 15, 9'h021, 0);
        push(1, 0,  9'h022, 0);
        push(1, 1,  9'h023, 0);
        push(1, 2,  9'h1FF, 0);
        push(0, 2,  9'h000, 1);
        run_check(1, -1);

        // Reset asserted between edges while PC=7
        for (int i = 0; i < 9; i++) rom0[i] = 9'h010 + 9'(i);
        rom0[9] = 9'h1FF;
        m_cnt = 0;
        push(0, 0, 9'h000, 0);
        for (int c = 1; c < 7; c++) push(1, 10'(c), rom0[c-1], 0);
        run_check(0, -1);
        check_val("pre-rst addr", b0.RomAddr, 10'd7);
        #2;
        Reset_n = 1'b0;
        #1;
        check_val("midrst addr",  b0.RomAddr, 10'd0);
        check_val("midrst valid", b0.InstrValid, 1'b0);
        check_val("midrst done",  b0.Done, 1'b0);
        check_val("midrst count", b0.InstrCount, 16'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        m_cnt = 0;
        push(0, 0, 9'h000, 0);
        for (int c = 1; c <= 10; c++) push(1, 10'(c), rom0[c-1], 0);
        push(0, 10, 9'h000, 1);
        run_check(0, -1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch sequencer for the single-cycle CPU: owns the program counter, addresses the synchronous instruction ROM and presents each fetched instruction, with its opcode field, to the control decoder. It is the producer of the opcode stream that the decoder consumes. It also consumes the decoder's branch indication, together with the ALU branch condition, to redirect the PC. Start/Done bracket a program run for the testbench or top level.

## Interface
- PCW, 10, program counter / ROM address width
- IW, 9, instruction width
- OPW, 3, opcode width; opcode = Instr[IW-1:IW-OPW]
- START_ADDR, 0, PC value at reset and on every Start
- HALT_INSTR, 9'h1FF, full instruction word that ends a run
- Clk  input  1  clock, all state updates on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- Start  input  1  begin a run from START_ADDR; honoured in IDLE and HALT only
- RomData  input  IW  ROM read data; valid the cycle after RomAddr is sampled
- Branch  input  1  decoder says current instruction is a branch
- BrTaken  input  1  ALU branch condition true
- BrTarget  input  PCW  absolute branch target
- RomAddr  output  PCW  current PC, drives ROM address
- Instr  output  IW  RomData passthrough, meaningful only when InstrValid=1
- ALUOp  output  OPW  opcode field of Instr
- InstrValid  output  1  Instr is a real, non-squashed instruction
- Done  output  1  run finished; held until Start or reset
- InstrCount  output  16  count of valid instructions presented this run

## Operation
- States: IDLE, RUN, HALT. Reset → IDLE.
- Reset values: RomAddr=START_ADDR, InstrValid=0, Done=0, InstrCount=0, squash flag=0.
- IDLE: PC held. Start=1 → RUN, InstrCount←0, squash flag←1, because the ROM has not yet produced data.
- RUN: each edge PC←PC+1, wrapping from 2^PCW−1 to 0. InstrValid = ~squash flag. Squash flag←0 unless a redirect happens.
- Redirect: on InstrValid & Branch & BrTaken, PC←BrTarget and squash flag←1. This discards the already-requested sequential word.
- Halt: InstrValid & Instr==HALT_INSTR → HALT. PC frozen at its current value. Halt has priority over a simultaneous redirect.
- InstrCount increments on every edge where InstrValid=1, including the halt instruction. It saturates at 16'hFFFF.
- HALT: Done=1, InstrValid=0. Start → RUN with PC←START_ADDR, Done←0, InstrCount←0, squash flag←1.
- Start asserted while in RUN is ignored.
- Reset_n low at any time, including mid-run, forces the reset values immediately, without waiting for Clk.

## Timing
- Start sampled at edge E0. Cycle after E0: RomAddr=START_ADDR, InstrValid=0.
- After E1: Instr=word[START_ADDR], InstrValid=1, RomAddr=START_ADDR+1.
- Steady state: one instruction per cycle, fetch latency 1 cycle from RomAddr.
- A taken branch in cycle k gives RomAddr=BrTarget and InstrValid=0 in cycle k+1, then word[BrTarget] valid in cycle k+2. Cost: one bubble.
- A not-taken branch costs nothing.
- A halt word valid in cycle k gives Done=1 from cycle k+1. ALUOp in cycle k reflects the halt word.
- ALUOp/Instr are combinational from RomData. Branch/BrTaken/BrTarget may be combinational from them within the same cycle.

## Structure
- fetch_pkg holds the state enum (IDLE, RUN, HALT) and the default widths and HALT_INSTR constant, shared with the decoder and top level.
- One sub-module, prog_ctr, is natural. It is the PCW-bit register with load (target/START_ADDR), increment-with-wrap and hold controls. The FSM, squash flag and counter stay in inst_fetch.

## Test plan
- Reset then Start, ROM words 0..3 = 9'h001, 9'h002, 9'h003, 9'h1FF. Required: InstrValid sequence 0,1,1,1,1, then Done=1, InstrCount=4, RomAddr frozen at 4.
- Taken branch: word 2 with Branch=1, BrTaken=1, BrTarget=10'd20. Required: RomAddr=20 next cycle with InstrValid=0, then word[20] valid; word 3 never valid.
- Not-taken branch: same word with BrTaken=0. Required: words 3, 4 follow with no bubble.
- Wrap: PCW=4, START_ADDR=14, no halt until address 1. Required: RomAddr sequence 14, 15, 0, 1; InstrCount increments across the wrap.
- Reset mid-run: Reset_n low between edges at PC=7. Required: RomAddr=0, InstrValid=0, Done=0 immediately. Start after release restarts at 0.
- Restart from HALT: Start in HALT with Done=1. Required: Done=0 next cycle, InstrCount=0, RomAddr=START_ADDR. A Start pulse during RUN leaves PC unaffected.
